// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared types, funct3 constants and helpers for mem_access_sequencer
package mem_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_LO,
        LOAD_HI,
        STORE,
        STORE_BYTE,
        RESP
    } state_e;

    localparam logic [2:0] FUNCT3_SB = 3'b000;
    localparam logic [2:0] FUNCT3_LD = 3'b011;

    // 111 is the only unused load encoding; stores stop at SD.
    function automatic logic load_legal(input logic [2:0] funct3);
        return funct3 != 3'b111;
    endfunction

    function automatic logic store_legal(input logic [2:0] funct3);
        return ~funct3[2];
    endfunction

    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

endpackage

// File: rtl/mem_access_sequencer_load_extract.sv
// rtl/mem_access_sequencer_load_extract.sv - byte-lane select and sign/zero extension of load data
module load_extract
    import mem_seq_pkg::*;
(
    input  logic [127:0] data_i,
    input  logic [2:0]   off_i,
    input  logic [2:0]   funct3_i,
    output logic [63:0]  result_o
);

    logic [63:0] window;

    assign window = 64'(data_i >> {off_i, 3'b000});

    always_comb begin
        result_o = window;
        case (funct3_i[1:0])
            2'd0: result_o = funct3_i[2] ? {56'd0, window[7:0]}  : {{56{window[7]}},  window[7:0]};
            2'd1: result_o = funct3_i[2] ? {48'd0, window[15:0]} : {{48{window[15]}}, window[15:0]};
            2'd2: result_o = funct3_i[2] ? {32'd0, window[31:0]} : {{32{window[31]}}, window[31:0]};
            default: result_o = window;
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - splits RV64 loads/stores into naturally aligned data_memory accesses
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_write_en_o,
    output logic [2:0]            mem_funct3_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   lo_q, lo_d;
    logic [DATA_WIDTH-1:0]   hi_q, hi_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [2:0]              k_q, k_d;
    logic                    write_q, write_d;
    logic                    err_q, err_d;

    logic [3:0]              size;
    logic [ADDR_WIDTH-1:0]   base;
    logic                    crossing;
    logic                    req_aligned;
    logic                    req_err;
    logic [63:0]             load_result;

    assign size        = size_bytes(funct3_q);
    assign base        = addr_q & ~ADDR_WIDTH'(7);
    assign crossing    = ({1'b0, addr_q[2:0]} + size) > 4'd8;
    assign req_aligned = (req_addr_i[2:0] & 3'(size_bytes(req_funct3_i) - 4'd1)) == 3'd0;
    assign req_err     = req_write_i ? ~store_legal(req_funct3_i) : ~load_legal(req_funct3_i);

    load_extract u_load_extract (
        .data_i   ({hi_q, lo_q}),
        .off_i    (addr_q[2:0]),
        .funct3_i (funct3_q),
        .result_o (load_result)
    );

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        lo_d           = lo_q;
        hi_d           = hi_q;
        funct3_d       = funct3_q;
        k_d            = k_q;
        write_d        = write_q;
        err_d          = err_q;
        resp_valid_o   = 1'b0;
        resp_rdata_o   = '0;
        resp_err_o     = 1'b0;
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        mem_write_en_o = 1'b0;
        mem_funct3_o   = FUNCT3_LD;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    funct3_d = req_funct3_i;
                    write_d  = req_write_i;
                    err_d    = req_err;
                    hi_d     = '0;
                    k_d      = 3'd0;
                    if (req_err)          state_d = RESP;
                    else if (!req_write_i) state_d = LOAD_LO;
                    else if (req_aligned) state_d = STORE;
                    else                  state_d = STORE_BYTE;
                end
            end
            LOAD_LO: begin
                mem_addr_o = base;
                lo_d       = mem_rdata_i;
                state_d    = crossing ? LOAD_HI : RESP;
            end
            LOAD_HI: begin
                mem_addr_o = base + ADDR_WIDTH'(8);
                hi_d       = mem_rdata_i;
                state_d    = RESP;
            end
            STORE: begin
                mem_write_en_o = 1'b1;
                mem_addr_o     = addr_q;
                mem_funct3_o   = funct3_q;
                mem_wdata_o    = wdata_q;
                state_d        = RESP;
            end
            STORE_BYTE: begin
                mem_write_en_o = 1'b1;
                mem_funct3_o   = FUNCT3_SB;
                mem_addr_o     = addr_q + ADDR_WIDTH'(k_q);
                mem_wdata_o    = DATA_WIDTH'(wdata_q[{k_q, 3'b000} +: 8]);
                if ({1'b0, k_q} == size - 4'd1) state_d = RESP;
                else                            k_d     = k_q + 3'd1;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                resp_err_o   = err_q;
                resp_rdata_o = (!write_q && !err_q) ? load_result : '0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is masked by rst so the pipeline sees no acceptance while reset is held.
    assign req_ready_o = (state_q == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            funct3_q <= '0;
            k_q      <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            funct3_q <= funct3_d;
            k_q      <= k_d;
            write_q  <= write_d;
            err_q    <= err_d;
        end
    end

endmodule
